result_bcd_converter: RTL and testbench
=======================================

// Module: result_bcd_converter
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) between the
//   calculator core and the 4-digit seven-segment driver. Launches on the rising edge of
//   the core's level-held done flag and converts the 28-bit result into OUT_DIGITS BCD
//   digits. Flags results that do not fit the display.
// PARAMETERS
//   IN_W        28   width of binary input
//   OUT_DIGITS  4    BCD digits presented on bcd_out (digit 0 = least significant)
//   localparam FULL_DIGITS = (IN_W*3)/10 + 1  internal BCD digits (9 at default), covers full IN_W range
// PORTS
//   clk         in   1              clock
//   reset       in   1              synchronous, active-low
//   start_in    in   1              level; conversion launches on its rising edge (connect core done)
//   bin_in      in   IN_W           binary value, sampled on the launch cycle only
//   busy        out  1              high while a conversion is in progress
//   done        out  1              one-cycle pulse: bcd_out/ovf/neg_out updated this cycle
//   bcd_out     out  4*OUT_DIGITS   packed BCD result, digit k at [4k+3:4k]
//   ovf         out  1              result magnitude > 10^OUT_DIGITS - 1
//   neg_out     out  1              result negative (NEG_DISPLAY_EN only, else constant 0)
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, neg_out=0,
//     start edge register=0, shift/BCD registers=0. Reset mid-conversion aborts; no done.
//   - Edge detect: launch = start_in & ~start_q; start_q <= start_in every cycle incl. BUSY.
//     start_in high on first cycle after reset counts as a rising edge.
//   - FSM IDLE -> CONV -> FIN -> IDLE:
//     IDLE: on launch capture bin_in (magnitude, see CONFIGURATION) into shift reg, clear
//           FULL_DIGITS BCD reg, counter=0, go CONV; busy=1 from next cycle.
//     CONV: per cycle, each BCD digit >=5 gets +3, then {bcd,shift} shifted left by 1;
//           counter increments; after IN_W shifts go FIN.
//     FIN:  bcd_out <= low OUT_DIGITS digits; ovf <= any upper digit nonzero; neg_out updated;
//           done=1 for this one cycle, busy=0 next cycle; return IDLE.
//   - Latency: launch at cycle 0 -> done high at cycle IN_W+1 (29 at default); busy high
//     cycles 1..IN_W+1. Throughput one conversion per IN_W+2 cycles.
//   - Launch edges during CONV/FIN are ignored (not queued); start_in held high never relaunches.
//   - bcd_out/ovf/neg_out hold last result until next FIN; unchanged during CONV.
//   - ovf case: bcd_out still shows low OUT_DIGITS digits (truncated decimal).
//   - All BCD digits always 0..9; arithmetic internal to IN_W + 4*FULL_DIGITS bit register.
// CONFIGURATION
//   NEG_DISPLAY_EN defined: bin_in is two's complement. If bin_in[IN_W-1]=1, magnitude
//     = -bin_in (IN_W bits, -2^(IN_W-1) -> 2^(IN_W-1)) is converted and neg_out=1 at FIN;
//     ovf judged on magnitude.
//   NEG_DISPLAY_EN undefined: bin_in unsigned, converted as-is, neg_out tied 0.
// TESTING
//   1. bin_in=1234, start_in 0->1 -> done at cycle 29, bcd_out=16'h1234, ovf=0, neg_out=0.
//   2. bin_in=0 then 9999 then 10000 (separate launches) -> 16'h0000/ovf=0, 16'h9999/ovf=0,
//      16'h0000/ovf=1.
//   3. start_in held high 200 cycles, bin_in=42 -> exactly one done pulse, bcd_out=16'h0042.
//   4. Second rising edge at cycle 10 of conversion with bin_in=7 -> ignored; first result
//      at cycle 29, no further done.
//   5. reset low at cycle 15 of conversion -> all outputs 0, no done; new launch with 5678
//      afterwards -> 16'h5678 after 29 cycles.
//   6. bin_in=28'hFFFFFFF: macro on -> neg_out=1, bcd_out=16'h0001, ovf=0;
//      macro off -> 268435455, bcd_out=16'h5455, ovf=1, neg_out=0.

Source files
------------

// File: rtl/result_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the display path.
// Optional feature macro: NEG_DISPLAY_EN (two's complement input, sign on neg_out).
module result_bcd_converter #(
  parameter int IN_W       = 28,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_in,
  input  logic [IN_W-1:0]         bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] bcd_out,
  output logic                    ovf,
  output logic                    neg_out
);

  localparam int FULL_DIGITS = (IN_W * 3) / 10 + 1;
  localparam int BCD_W       = 4 * FULL_DIGITS;
  localparam int OUT_W       = 4 * OUT_DIGITS;
  localparam int CNT_W       = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  state_t state, state_nx;

  logic             start_q;
  logic             launch;
  logic             sign;
  logic [IN_W-1:0]  mag;
  logic [IN_W-1:0]  shift_q;
  logic [IN_W-1:0]  shift_nx;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             last;
  logic             neg_q;
  logic             neg_r;

  assign launch = start_in & ~start_q;
  assign last   = (cnt_q == CNT_W'(IN_W - 1));

`ifdef NEG_DISPLAY_EN
  assign sign = bin_in[IN_W-1];
  assign mag  = sign ? -bin_in : bin_in;
`else
  assign sign = 1'b0;
  assign mag  = bin_in;
`endif

  // Add 3 to every digit >= 5, then shift the whole BCD:binary pair left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < FULL_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    {bcd_nx, shift_nx} = {bcd_adj, shift_q} << 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; busy covers CONV and FIN, done marks the FIN cycle.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch) state_nx = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last) state_nx = FIN;
      end
      FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: launch capture, per-bit conversion, result load on the last shift
  // so the outputs are already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      start_q <= start_in;
      if (state == IDLE && launch) begin
        shift_q <= mag;
        bcd_q   <= '0;
        cnt_q   <= '0;
        neg_q   <= sign;
      end else if (state == CONV) begin
        shift_q <= shift_nx;
        bcd_q   <= bcd_nx;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last) begin
          bcd_out <= bcd_nx[OUT_W-1:0];
          ovf     <= |bcd_nx[BCD_W-1:OUT_W];
          neg_r   <= neg_q;
        end
      end
    end
  end

  assign neg_out = neg_r;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Randomized self-checking bench for result_bcd_converter.
// Expected values come from a decimal arithmetic model.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [27:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;
  logic        neg_out;

  int checks = 0;
  int failures = 0;

  logic [15:0] prev_b;
  logic        prev_o;
  logic        prev_n;

  result_bcd_converter dut (
    .clk     (clk),
    .reset   (reset),
    .start_in(start_in),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .neg_out (neg_out)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [27:0] v,
                                output logic [15:0] b,
                                output logic o,
                                output logic n);
    longint m;
    m = longint'(v);
    n = 1'b0;
`ifdef NEG_DISPLAY_EN
    if (v[27]) begin
      m = 64'd268435456 - longint'(v);
      n = 1'b1;
    end
`endif
    o = (m > 9999);
    for (int k = 0; k < 4; k++) begin
      b[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  // Launch one conversion and check latency, busy, hold and result.
  task automatic do_conv(input logic [27:0] v, input string name);
    logic [15:0] eb;
    logic eo, en;
    int n;
    bit seen;
    model(v, eb, eo, en);
    @(negedge clk);
    bin_in = v;
    start_in = 1'b1;
    seen = 0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_c1 got=%b exp=1", name, busy);
        end
      end
      if (n == 15) begin
        checks++;
        if (bcd_out !== prev_b || ovf !== prev_o || neg_out !== prev_n) begin
          failures++;
          $display("FAIL %s hold got=%h/%b/%b exp=%h/%b/%b",
                   name, bcd_out, ovf, neg_out, prev_b, prev_o, prev_n);
        end
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    start_in = 1'b0;
    checks++;
    if (!seen || n != 29) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=29", name, seen ? n : -1);
    end
    checks++;
    if (bcd_out !== eb || ovf !== eo || neg_out !== en) begin
      failures++;
      $display("FAIL %s result v=%h got=%h/%b/%b exp=%h/%b/%b",
               name, v, bcd_out, ovf, neg_out, eb, eo, en);
    end
    prev_b = eb;
    prev_o = eo;
    prev_n = en;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done got busy=%b done=%b exp=0/0", name, busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start_in = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bcd_out, ovf, neg_out} !== 20'h0) begin
      failures++;
      $display("FAIL reset got=%b/%b/%h/%b/%b exp=0", busy, done, bcd_out, ovf, neg_out);
    end
    reset = 1'b1;
    @(negedge clk);
    prev_b = '0;
    prev_o = 1'b0;
    prev_n = 1'b0;
  endtask

  task automatic test_directed;
    do_conv(28'd1234, "d1234");
    do_conv(28'd0, "d0");
    do_conv(28'd9999, "d9999");
    do_conv(28'd10000, "d10000");
    do_conv(28'hFFFFFFF, "dall1");
    do_conv(28'h8000000, "dmsb");
  endtask

  task automatic test_random;
    logic [27:0] v;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: v = 28'($urandom_range(0, 9999));
        1: v = 28'($urandom_range(9990, 10010));
        2: v = 28'($urandom);
        default: v = 28'hFFFFFFF - 28'($urandom_range(0, 20000));
      endcase
      do_conv(v, "rand");
    end
  endtask

  task automatic test_held_high;
    int cnt;
    bin_in = 28'd42;
    start_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    start_in = 1'b0;
    checks++;
    if (cnt != 1) begin
      failures++;
      $display("FAIL held_pulses got=%0d exp=1", cnt);
    end
    checks++;
    if (bcd_out !== 16'h0042 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL held_result got=%h/%b exp=0042/0", bcd_out, ovf);
    end
    prev_b = 16'h0042;
    prev_o = 1'b0;
    prev_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored_edge;
    logic [15:0] eb;
    logic eo, en;
    int cnt, first;
    model(28'd8765, eb, eo, en);
    bin_in = 28'd8765;
    start_in = 1'b1;
    cnt = 0;
    first = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) start_in = 1'b0;
      if (n == 10) begin
        start_in = 1'b1;
        bin_in = 28'd7;
      end
      if (done === 1'b1) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    start_in = 1'b0;
    checks++;
    if (cnt != 1 || first != 29) begin
      failures++;
      $display("FAIL ignore_edge got=%0d@%0d exp=1@29", cnt, first);
    end
    checks++;
    if (bcd_out !== eb || ovf !== eo) begin
      failures++;
      $display("FAIL ignore_result got=%h/%b exp=%h/%b", bcd_out, ovf, eb, eo);
    end
    prev_b = eb;
    prev_o = eo;
    prev_n = en;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int cnt;
    do_conv(28'd4321, "pre_abort");
    bin_in = 28'd9876;
    start_in = 1'b1;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    start_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, bcd_out, ovf, neg_out} !== 20'h0) begin
      failures++;
      $display("FAIL abort_out got=%b/%b/%h/%b/%b exp=0", busy, done, bcd_out, ovf, neg_out);
    end
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL abort_done got=%0d exp=0", cnt);
    end
    prev_b = '0;
    prev_o = 1'b0;
    prev_n = 1'b0;
    do_conv(28'd5678, "post_abort");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_held_high;
    test_ignored_edge;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
